aes_block_loader: RTL and testbench
===================================

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 SHALL have parameter ZEROIZE, default 1: when 1, the assembly register is cleared to zero once its block has been handed to the output register.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port clear, input, 1: synchronous discard of the partial block and of any pending output block.
REQ-005 SHALL have port in_byte, input, 8: plaintext byte, first byte of a block first.
REQ-006 SHALL have port in_valid, input, 1: in_byte is valid.
REQ-007 SHALL have port in_ready, output, 1: loader accepts in_byte this cycle.
REQ-008 SHALL have port out_block, output, [0:127]: assembled 128-bit state for the AES top "in" port.
REQ-009 SHALL have port out_valid, output, 1: out_block holds a complete block.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes out_block this cycle.
REQ-011 SHALL have port byte_count, output, 4: number of bytes held in the current partial block (0-15).

Function
REQ-012 SHALL accept a byte exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-013 SHALL write the byte accepted at count k (0-15) into assembly bits [8k:8k+7], so the first byte lands in out_block[0:7].
REQ-014 SHALL increment byte_count on each accept and wrap it from 15 to 0 on the 16th accept.
REQ-015 SHALL, on the 16th accept, copy the completed assembly (including that byte) to out_block and set out_valid on the next cycle, giving 1-cycle latency.
REQ-016 SHALL complete an output handshake when out_valid and out_ready are both 1, and clear out_valid at that edge unless a new block loads at the same edge.
REQ-017 SHALL hold out_block and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL give priority to a 16th accept over a simultaneous output handshake: the new block loads and out_valid stays 1.
REQ-019 SHALL ignore out_ready while out_valid=0; out_block is don't-care-stable (unchanged) then.
REQ-020 SHALL, on clear=1, set byte_count=0 and out_valid=0, drop any input byte offered that cycle, and leave in_ready at 1 in the following cycle.
REQ-021 SHALL zero the assembly register at the 16th accept when ZEROIZE=1, and leave it unchanged when ZEROIZE=0.
REQ-022 SHALL keep in_ready purely a function of registered state, out_valid and out_ready, with no combinational path from in_valid.

Reset
REQ-023 SHALL, on clk edge with rst_n=0, set out_valid=0, out_block=0, byte_count=0 and the assembly register to 0.
REQ-024 SHALL drive in_ready=0 while rst_n=0 and in_ready=1 in the first cycle after release.
REQ-025 SHALL abandon any partial or pending block when reset asserts mid-operation, with no output emitted.
REQ-026 SHALL give reset priority over clear and over all handshakes.

Configuration
REQ-027 SHALL use macro AES_LOADER_DOUBLE_BUF_EN to select buffering.
REQ-028 SHALL, without AES_LOADER_DOUBLE_BUF_EN, drive in_ready=0 whenever out_valid=1, so no byte is collected until the pending block is consumed.
REQ-029 SHALL, with AES_LOADER_DOUBLE_BUF_EN, keep collecting while out_valid=1 and drive in_ready=0 only when byte_count=15, out_valid=1 and out_ready=0.

Verification
REQ-030 SHALL verify a single block: bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 on consecutive cycles with out_ready=1 -> one cycle after the 16th byte, out_valid=1 and out_block=193de3bea0f4e22b9ac68d2ae9f84808; byte_count=0.
REQ-031 SHALL verify backpressure: same block with out_ready=0 for 10 cycles -> out_block stable and out_valid=1 throughout; without the macro in_ready=0, with the macro 15 further bytes accepted and the 16th stalled.
REQ-032 SHALL verify the simultaneous event (macro on): 16th byte of block B accepted in the same cycle out_ready=1 for block A -> next cycle out_block=B and out_valid stays 1.
REQ-033 SHALL verify clear: assert clear after 7 bytes -> byte_count=0, and 16 new bytes 00..0f give out_block=000102030405060708090a0b0c0d0e0f.
REQ-034 SHALL verify reset mid-block: rst_n=0 for 1 cycle after 9 bytes -> out_valid=0, out_block=0, byte_count=0, and no block is emitted until 16 further bytes are accepted.
REQ-035 SHALL verify gapped input: in_valid toggling 1/0 over 32 cycles -> exactly one block, with byte order identical to REQ-030.

Source files
------------

// File: rtl/aes_block_loader.sv
// AES block loader: packs a byte stream into 128-bit blocks, first byte in out_block[0:7].
// Optional macro AES_LOADER_DOUBLE_BUF_EN keeps collecting while an output block is pending.
module aes_block_loader #(
    parameter logic ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   byte_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [0:127] asm_q;
    logic [0:127] asm_d;
    logic [0:127] blk_q;
    logic [0:127] blk_d;
    logic [0:127] merged;
    logic [6:0]   slot;
    logic         stall;
    logic         accept;
    logic         last;

    assign out_valid  = (state_q == ST_FULL);
    assign out_block  = blk_q;
    assign byte_count = cnt_q;

`ifdef AES_LOADER_DOUBLE_BUF_EN
    // Only the 16th byte must wait: it would overwrite a block nobody has taken yet.
    assign stall = out_valid && !out_ready && (cnt_q == 4'd15);
`else
    // Single buffer: collection pauses until the pending block is consumed.
    assign stall = out_valid;
`endif

    // Held low during reset so nothing is offered as accepted before state is known.
    assign in_ready = rst_n && !stall;

    assign slot   = {cnt_q, 3'b000};
    assign accept = in_valid && in_ready && !clear;
    assign last   = accept && (cnt_q == 4'd15);

    // Assembly register with the incoming byte dropped into its slot.
    always_comb begin
        merged = asm_q;
        merged[slot +: 8] = in_byte;
    end

    // Next-state: byte collection, block hand-off and output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        blk_d   = blk_q;
        if (clear) begin
            state_d = ST_EMPTY;
            cnt_d   = 4'd0;
            asm_d   = '0;
        end else begin
            if (accept) begin
                cnt_d = cnt_q + 4'd1;
                asm_d = merged;
            end
            if (last) begin
                blk_d = merged;
                if (ZEROIZE) begin
                    asm_d = '0;
                end
            end
            unique case (state_q)
                ST_EMPTY: begin
                    if (last) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!last && out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State registers; reset wins over clear and every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= 4'd0;
            asm_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed testbench for aes_block_loader.
// Covers single block, backpressure, clear, mid-block reset and gapped input.
module tb_aes_block_loader;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] out_block;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   byte_count;

    int n_assert;
    int n_fail;

    logic [0:127] kblk;
    logic [0:127] seq;
    logic [0:127] rblk;
    logic [0:127] held;
    logic [0:127] got;
    int           blocks;

    aes_block_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_block  (out_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_byte  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 50) begin
                n_assert++;
                n_fail++;
                $error("FAIL push_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        kblk      = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        seq       = 128'h000102030405060708090a0b0c0d0e0f;
        rblk      = 128'h101112131415161718191a1b1c1d1e1f;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_block", out_block, 0);
        check("rst_byte_count", byte_count, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("rel_in_ready_edge", in_ready, 1);

        // Single block, consecutive bytes, out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(kblk[8*i +: 8]);
            if (i == 0) check("one_count1", byte_count, 1);
        end
        check("one_valid", out_valid, 1);
        check("one_block", out_block, kblk);
        check("one_count", byte_count, 0);
        @(posedge clk);
        #1;
        check("one_consumed", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(kblk[8*i +: 8]);
        check("bp_valid", out_valid, 1);
        check("bp_block", out_block, kblk);
`ifdef AES_LOADER_DOUBLE_BUF_EN
        for (int i = 0; i < 15; i++) push(seq[8*i +: 8]);
        check("bp_count15", byte_count, 15);
        in_valid = 1'b1;
        in_byte  = 8'h0f;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_block", out_block, kblk);
            check("bp_hold_count", byte_count, 15);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sim_valid", out_valid, 1);
        check("sim_block", out_block, seq);
        check("sim_count", byte_count, 0);
        @(posedge clk);
        #1;
        check("sim_consumed", out_valid, 0);
`else
        in_valid = 1'b1;
        in_byte  = 8'haa;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_block", out_block, kblk);
            check("bp_hold_count", byte_count, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_consumed", out_valid, 0);
        check("bp_after_count", byte_count, 0);
`endif

        // Clear a partial block
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(8'hff);
        check("clr_pre_count", byte_count, 7);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_count", byte_count, 0);
        check("clr_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) push(seq[8*i +: 8]);
        check("clr_blk_valid", out_valid, 1);
        check("clr_blk", out_block, seq);
        @(posedge clk);
        #1;
        check("clr_consumed", out_valid, 0);

        // Clear drops a pending output block
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(kblk[8*i +: 8]);
        check("clrp_valid", out_valid, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clrp_dropped", out_valid, 0);
        check("clrp_in_ready", in_ready, 1);

        // Reset in the middle of a block
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) push(kblk[8*i +: 8]);
        check("rm_pre_count", byte_count, 9);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rm_in_ready_low", in_ready, 0);
        rst_n = 1'b1;
        check("rm_valid", out_valid, 0);
        check("rm_block", out_block, 0);
        check("rm_count", byte_count, 0);
        for (int i = 0; i < 15; i++) push(rblk[8*i +: 8]);
        check("rm_no_early", out_valid, 0);
        check("rm_count15", byte_count, 15);
        push(rblk[120 +: 8]);
        check("rm_blk_valid", out_valid, 1);
        check("rm_blk", out_block, rblk);
        @(posedge clk);
        #1;
        check("rm_consumed", out_valid, 0);

        // Gapped input over 32 cycles
        blocks = 0;
        got    = '0;
        for (int i = 0; i < 32; i++) begin
            in_valid = (i % 2 == 0);
            in_byte  = kblk[8*(i/2) +: 8];
            @(posedge clk);
            #1;
            if (out_valid) begin
                blocks++;
                got = out_block;
            end
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid) blocks++;
        end
        check("gap_blocks", blocks, 1);
        check("gap_block", got, kblk);
        check("gap_count", byte_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
